cma_host_ctrl: RTL and testbench

// - Host-side sequencer for the CMA accelerator chip (CMA_TOP): after reset it

---
 rtl/cma_pkg.sv | 26 ++
 rtl/cma_init_rom.sv | 23 ++
 rtl/cma_host_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cma_host_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cma_pkg.sv
// Shared types and widths for the CMA host sequencer.
// Optional checksum output is enabled by defining CMA_CHECKSUM_EN.
package cma_pkg;

    localparam int DATA_W  = 16;
    localparam int EXA_W   = 10;
    localparam int ROMUL_W = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        WAIT_ST,
        LOAD,
        RUN_ST,
        DRAIN,
        READ,
        FLUSH,
        END_ST
    } cma_state_t;

    typedef struct packed {
        logic [ROMUL_W-1:0] romul;
        logic [EXA_W-1:0]   addr;
        logic [DATA_W-1:0]  data;
    } img_entry_t;

endpackage

// File: rtl/cma_init_rom.sv
// Load-phase image store: combinational lookup of entry idx.
// Default image is entry i = {romul=i[7:0], addr=i, data=i*3}.
module cma_init_rom
    import cma_pkg::*;
#(
    parameter int N_LOAD = 64,
    parameter int IDX_W  = 6
) (
    input  logic [IDX_W-1:0] idx,
    output img_entry_t       entry
);

    // Indices past the image read as zero so a wide counter cannot alias.
    always_comb begin
        entry = '0;
        if (int'(idx) < N_LOAD) begin
            entry.romul = ROMUL_W'(idx);
            entry.addr  = EXA_W'(idx);
            entry.data  = DATA_W'(idx) * DATA_W'(3);
        end
    end

endmodule

// File: rtl/cma_host_ctrl.sv
// Host sequencer for CMA_TOP: load image, RUN until DONE, read a result window.
// Define CMA_CHECKSUM_EN to add the CHKSUM output (XOR of captured words).
module cma_host_ctrl
    import cma_pkg::*;
#(
    parameter int   N_LOAD    = 64,
    parameter int   START_DLY = 100,
    parameter int   RD_BASE   = 0,
    parameter int   RD_CNT    = 32,
    parameter logic BANK      = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [EXA_W-1:0]   EXA,
    output logic [DATA_W-1:0]  EXWD,
    output logic [ROMUL_W-1:0] EXROMUL,
    output logic               EXWE,
    output logic               EXRE,
    input  logic [DATA_W-1:0]  EXRD,
    output logic               RUN,
    output logic               BANK_SEL,
    input  logic               DONE,
    output logic [DATA_W-1:0]  RD_DATA,
    output logic               RD_VLD,
    output logic               FIN
`ifdef CMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]  CHKSUM
`endif
);

    localparam int IDX_W = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;

    cma_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  rom_idx;
    img_entry_t        ent;
    logic              load_n, read_n, run_n, fin_n, re_d1;
    logic [EXA_W-1:0]   exa_n;
    logic [DATA_W-1:0]  exwd_n;
    logic [ROMUL_W-1:0] romul_n;

    // Outputs are registered, so the ROM is read one entry ahead of the write.
    assign rom_idx = (state == LOAD) ? IDX_W'(cnt + 1'b1) : '0;

    cma_init_rom #(
        .N_LOAD (N_LOAD),
        .IDX_W  (IDX_W)
    ) u_rom (
        .idx   (rom_idx),
        .entry (ent)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        load_n  = 1'b0;
        read_n  = 1'b0;
        run_n   = 1'b0;
        fin_n   = 1'b0;
        case (state)
            WAIT_ST: if (cnt == CNT_W'(START_DLY - 1)) begin
                state_n = LOAD;
                cnt_n   = '0;
                load_n  = 1'b1;
            end
            LOAD: if (cnt == CNT_W'(N_LOAD - 1)) begin
                state_n = RUN_ST;
                cnt_n   = '0;
                run_n   = 1'b1;
            end else begin
                load_n  = 1'b1;
            end
            RUN_ST: if (DONE) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end else begin
                run_n   = 1'b1;
            end
            DRAIN: if (cnt == CNT_W'(1)) begin
                state_n = READ;
                cnt_n   = '0;
                read_n  = 1'b1;
            end
            READ: if (cnt == CNT_W'(RD_CNT - 1)) begin
                state_n = FLUSH;
                cnt_n   = '0;
            end else begin
                read_n  = 1'b1;
            end
            FLUSH: if (cnt == CNT_W'(1)) begin
                state_n = END_ST;
                cnt_n   = '0;
                fin_n   = 1'b1;
            end
            END_ST: begin
                cnt_n   = cnt;
                fin_n   = 1'b1;
            end
            default: begin
                state_n = WAIT_ST;
                cnt_n   = '0;
            end
        endcase

        exa_n   = '0;
        exwd_n  = '0;
        romul_n = '0;
        if (load_n) begin
            exa_n   = ent.addr;
            exwd_n  = ent.data;
            romul_n = ent.romul;
        end else if (read_n) begin
            exa_n   = EXA_W'(RD_BASE) + cnt_n[EXA_W-1:0];
        end
    end

    // Read data arrives the cycle after EXRE, and is captured one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= WAIT_ST;
            cnt      <= '0;
            EXA      <= '0;
            EXWD     <= '0;
            EXROMUL  <= '0;
            EXWE     <= 1'b0;
            EXRE     <= 1'b0;
            RUN      <= 1'b0;
            BANK_SEL <= 1'b0;
            FIN      <= 1'b0;
            re_d1    <= 1'b0;
            RD_VLD   <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            EXA      <= exa_n;
            EXWD     <= exwd_n;
            EXROMUL  <= romul_n;
            EXWE     <= load_n;
            EXRE     <= read_n;
            RUN      <= run_n;
            BANK_SEL <= run_n & BANK;
            FIN      <= fin_n;
            re_d1    <= EXRE;
            RD_VLD   <= re_d1;
            if (re_d1) begin
                RD_DATA <= EXRD;
            end
        end
    end

`ifdef CMA_CHECKSUM_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CHKSUM <= '0;
        end else if (re_d1) begin
            CHKSUM <= CHKSUM ^ EXRD;
        end
    end
`endif

endmodule

// File: tb/tb_cma_host_ctrl.sv
// Self-checking bench for cma_host_ctrl with a chip memory/DONE responder.
// Checks CHKSUM as well when CMA_CHECKSUM_EN is defined.
module tb_cma_host_ctrl;

    localparam int   DATA_W    = 16;
    localparam int   EXA_W     = 10;
    localparam int   ROMUL_W   = 8;
    localparam int   N_LOAD    = 64;
    localparam int   START_DLY = 100;
    localparam int   RD_BASE   = 0;
    localparam int   RD_CNT    = 32;
    localparam logic BANK      = 1'b1;
    localparam int   DONE_DLY  = 20;
    localparam int   RUN_START = START_DLY + N_LOAD;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic [EXA_W-1:0]   EXA;
    logic [DATA_W-1:0]  EXWD;
    logic [ROMUL_W-1:0] EXROMUL;
    logic               EXWE, EXRE, RUN, BANK_SEL, RD_VLD, FIN;
    logic [DATA_W-1:0]  EXRD = '0;
    logic               DONE = 1'b0;
    logic [DATA_W-1:0]  RD_DATA;
`ifdef CMA_CHECKSUM_EN
    logic [DATA_W-1:0]  CHKSUM;
`endif

    int checks = 0;
    int errors = 0;
    int done_mode = 0;

    int cyc, run_rise, run_end, run_cycles, vld_cnt, prev_addr;
    int load_i, rs, rd_k, vld_k, exa_exp;
    bit prev_re, in_load, in_run, in_read, in_vld, fin_exp, fin_checked;
    logic [DATA_W-1:0] exp_xor;

    cma_host_ctrl #(
        .N_LOAD    (N_LOAD),
        .START_DLY (START_DLY),
        .RD_BASE   (RD_BASE),
        .RD_CNT    (RD_CNT),
        .BANK      (BANK)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EXA      (EXA),
        .EXWD     (EXWD),
        .EXROMUL  (EXROMUL),
        .EXWE     (EXWE),
        .EXRE     (EXRE),
        .EXRD     (EXRD),
        .RUN      (RUN),
        .BANK_SEL (BANK_SEL),
        .DONE     (DONE),
        .RD_DATA  (RD_DATA),
        .RD_VLD   (RD_VLD),
        .FIN      (FIN)
`ifdef CMA_CHECKSUM_EN
        ,
        .CHKSUM   (CHKSUM)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] memWord(input int a);
        return DATA_W'(a & ((1 << EXA_W) - 1)) ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h cycle=%0d t=%0t",
                     name, act, exp, cyc, $time);
        end
    endtask

    // Phase windows derived from the sequence timeline; checked each cycle.
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            cyc = 0; run_rise = -1; run_end = -1; run_cycles = 0; vld_cnt = 0;
            prev_re = 1'b0; prev_addr = 0; fin_checked = 1'b0; exp_xor = '0;
            DONE = (done_mode == 1);
            EXRD = '0;
        end else begin
            cyc++;
            load_i  = cyc - START_DLY;
            in_load = (load_i >= 0) && (load_i < N_LOAD);
            in_run  = (cyc >= RUN_START) && ((run_end < 0) || (cyc < run_end));
            rs      = (run_end < 0) ? (1 << 30) : run_end + 2;
            rd_k    = cyc - rs;
            vld_k   = rd_k - 2;
            in_read = (run_end >= 0) && (rd_k >= 0) && (rd_k < RD_CNT);
            in_vld  = (run_end >= 0) && (vld_k >= 0) && (vld_k < RD_CNT);
            fin_exp = (run_end >= 0) && (cyc >= rs + RD_CNT + 2);
            exa_exp = in_load ? load_i : (in_read ? ((RD_BASE + rd_k) % (1 << EXA_W)) : 0);

            checkOutput("exwe", EXWE, in_load);
            checkOutput("exa", EXA, exa_exp);
            checkOutput("exwd", EXWD, in_load ? 3 * load_i : 0);
            checkOutput("exromul", EXROMUL, in_load ? (load_i & 255) : 0);
            checkOutput("exre", EXRE, in_read);
            checkOutput("run", RUN, in_run);
            checkOutput("bank_sel", BANK_SEL, in_run ? BANK : 1'b0);
            checkOutput("rd_vld", RD_VLD, in_vld);
            checkOutput("fin", FIN, fin_exp);

            if (cyc == START_DLY) begin
                checkOutput("first_write_exa", EXA, 0);
                checkOutput("first_write_exwd", EXWD, 0);
            end
            if (cyc == START_DLY + N_LOAD - 1) begin
                checkOutput("last_write_exa", EXA, 63);
                checkOutput("last_write_exwd", EXWD, 189);
            end
            if (in_vld) begin
                checkOutput("rd_data", RD_DATA, memWord(RD_BASE + vld_k));
                exp_xor ^= memWord(RD_BASE + vld_k);
                if (vld_k == 0)  checkOutput("rd_data_first", RD_DATA, 16'h5A5A);
                if (vld_k == 31) checkOutput("rd_data_last", RD_DATA, 16'h5A45);
            end
            if (RD_VLD) vld_cnt++;
            if (RUN) begin
                run_cycles++;
                if (run_rise < 0) run_rise = cyc;
            end
`ifdef CMA_CHECKSUM_EN
            if (fin_exp && !fin_checked) begin
                checkOutput("chksum_model", CHKSUM, exp_xor);
                checkOutput("chksum_value", CHKSUM, 16'h0000);
            end
`endif
            if (fin_exp) fin_checked = 1'b1;

            // Chip side: registered memory read and the DONE generator.
            if (prev_re) EXRD = memWord(prev_addr);
            prev_re   = EXRE;
            prev_addr = int'(EXA);
            DONE = (done_mode == 1) ? 1'b1 : ((run_rise >= 0) && (cyc >= run_rise + DONE_DLY));
            if (DONE && (cyc >= RUN_START) && (run_end < 0)) run_end = cyc + 1;
        end
    end

    task automatic resetDut();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("rst_exa", EXA, 0);
        checkOutput("rst_exwd", EXWD, 0);
        checkOutput("rst_exromul", EXROMUL, 0);
        checkOutput("rst_exwe", EXWE, 0);
        checkOutput("rst_exre", EXRE, 0);
        checkOutput("rst_run", RUN, 0);
        checkOutput("rst_bank_sel", BANK_SEL, 0);
        checkOutput("rst_rd_data", RD_DATA, 0);
        checkOutput("rst_rd_vld", RD_VLD, 0);
        checkOutput("rst_fin", FIN, 0);
`ifdef CMA_CHECKSUM_EN
        checkOutput("rst_chksum", CHKSUM, 0);
`endif
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic applyStimulus(input int mode, input bit abort_in_read);
        int waited;
        done_mode = mode;
        resetDut();
        waited = 0;
        if (abort_in_read) begin
            while (EXRE !== 1'b1 && waited < 1000) begin
                @(negedge CLK);
                waited++;
            end
            checkOutput("read_reached", EXRE, 1);
            repeat (10) @(negedge CLK);
            return;
        end
        while (FIN !== 1'b1 && waited < 2000) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("fin_reached", FIN, 1);
        repeat (5) @(negedge CLK);
        checkOutput("run_cycles", run_cycles, (mode == 1) ? 1 : DONE_DLY + 1);
        checkOutput("vld_pulses", vld_cnt, RD_CNT);
    endtask

    initial begin
        $display("[TB] DONE after %0d cycles of RUN", DONE_DLY);
        applyStimulus(0, 1'b0);
        $display("[TB] reset pulsed during READ, then full rerun");
        applyStimulus(0, 1'b1);
        applyStimulus(0, 1'b0);
        $display("[TB] DONE tied high");
        applyStimulus(1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
